// File: rtl/aes_pkg.sv
// Shared widths, FSM encoding and GF(2^8) helpers for the AES-128 decrypt controller.
package aes_pkg;

  localparam int unsigned BLOCK_W           = 128;
  localparam int unsigned CNT_W             = 8;
  localparam int unsigned SETTLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = gmul(a, a);
    for (int i = 1; i < 8; i++) begin
      r  = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Block handshake and status bundle between the decrypt controller and its host.
interface aes_dec_ctrl_if;

  logic                         key_wr;
  logic [aes_pkg::BLOCK_W-1:0]  key_in;
  logic                         in_valid;
  logic                         in_ready;
  logic [aes_pkg::BLOCK_W-1:0]  in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [aes_pkg::BLOCK_W-1:0]  out_data;
  logic                         busy;
  logic                         key_valid;
  logic                         key_err;
  logic [15:0]                  blk_count;

  modport master (
    output key_wr, key_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, key_valid, key_err, blk_count
  );

  modport slave (
    input  key_wr, key_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, key_valid, key_err, blk_count
  );

endinterface

// File: rtl/Decrypt.sv
// Combinational AES-128 inverse cipher: full key expansion plus ten inverse rounds.
module Decrypt
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] result
);

  function automatic logic [BLOCK_W-1:0] inv_cipher(input logic [BLOCK_W-1:0] ct,
                                                    input logic [BLOCK_W-1:0] k);
    logic [31:0]        w [44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [BLOCK_W-1:0] s;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = ct ^ {w[40], w[41], w[42], w[43]};
    for (int r = 9; r >= 0; r--) begin
      s = inv_sub_bytes(inv_shift_rows(s)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r > 0) s = inv_mix_columns(s);
    end
    return s;
  endfunction

  assign result = inv_cipher(state, key);

endmodule

// File: rtl/aes_dec_ctrl.sv
// Controller that feeds the combinational Decrypt core from stable registers, waits a
// fixed settle time, then presents the registered plaintext on a valid/ready port.
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_dec_ctrl_if.slave  bus
);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BLOCK_W-1:0]  r_blk;
  logic [BLOCK_W-1:0]  r_key;
  logic [BLOCK_W-1:0]  r_out;
  logic                r_out_valid;
  logic                r_key_valid;
  logic                r_key_err;
  logic [15:0]         r_blk_count;

  logic [BLOCK_W-1:0]  w_result;
  logic                w_in_ready;

  Decrypt u_decrypt (
    .state  (r_blk),
    .key    (r_key),
    .result (w_result)
  );

  // A key write in IDLE takes priority, so a block is never accepted alongside it.
  assign w_in_ready    = (r_state == ST_IDLE) & r_key_valid & ~bus.key_wr;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.key_valid = r_key_valid;
  assign bus.key_err   = r_key_err;
  assign bus.blk_count = r_blk_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_blk       <= '0;
      r_key       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_blk_count <= '0;
    end else begin
      r_key_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.key_wr) begin
            r_key       <= bus.key_in;
            r_key_valid <= 1'b1;
          end else if (bus.in_valid && w_in_ready) begin
            r_blk   <= bus.in_data;
            r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_key_err <= bus.key_wr;
          if (r_cnt == '0) begin
            r_out       <= w_result;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_key_err <= bus.key_wr;
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_blk_count <= r_blk_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl using the FIPS-197 AES-128 vector.
module tb_aes_dec_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BAD = 128'hdeadbeefcafef00d0123456789abcdef;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  aes_dec_ctrl_if bus();

  aes_dec_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Steps until out_valid is seen (bounded); returns number of edges waited.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"},  128'(bus.in_ready),  128'(0));
    check_eq({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    check_eq({tag, "_out_data"},  bus.out_data,        128'(0));
    check_eq({tag, "_busy"},      128'(bus.busy),      128'(0));
    check_eq({tag, "_key_valid"}, 128'(bus.key_valid), 128'(0));
    check_eq({tag, "_key_err"},   128'(bus.key_err),   128'(0));
    check_eq({tag, "_blk_count"}, 128'(bus.blk_count), 128'(0));
  endtask

  initial begin
    bus.key_wr    = 1'b0;
    bus.key_in    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check_all_zero("rst");
    rst_n = 1'b1;
    step();

    // No key loaded: block must never be taken
    bus.in_valid = 1'b1;
    bus.in_data  = CT;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("nokey_in_ready",  128'(bus.in_ready),  128'(0));
      check_eq("nokey_busy",      128'(bus.busy),      128'(0));
      check_eq("nokey_out_valid", 128'(bus.out_valid), 128'(0));
    end
    bus.in_valid = 1'b0;

    // Key load
    bus.key_wr = 1'b1;
    bus.key_in = KEY;
    step();
    bus.key_wr = 1'b0;
    #1;
    check_eq("key_valid", 128'(bus.key_valid), 128'(1));
    check_eq("key_busy",  128'(bus.busy),      128'(0));

    // FIPS-197 block with out_ready high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = CT;
    #1;
    check_eq("fips_in_ready", 128'(bus.in_ready), 128'(1));
    step();
    bus.in_valid = 1'b0;
    check_eq("fips_busy", 128'(bus.busy), 128'(1));
    wait_out("fips", lat);
    check_eq("fips_latency", 128'(lat), 128'(4));
    check_eq("fips_out_data", bus.out_data, PT);
    step();
    check_eq("fips_out_valid_drop", 128'(bus.out_valid), 128'(0));
    check_eq("fips_blk_count",      128'(bus.blk_count), 128'(1));
    check_eq("fips_idle",           128'(bus.busy),      128'(0));

    // Backpressure, with a competing block offered while busy
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = CT;
    step();
    bus.in_data = BAD;
    wait_out("bp", lat);
    check_eq("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_out_valid", 128'(bus.out_valid), 128'(1));
      check_eq("bp_out_data",  bus.out_data,        PT);
      check_eq("bp_in_ready",  128'(bus.in_ready),  128'(0));
      check_eq("bp_blk_count", 128'(bus.blk_count), 128'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_release_valid", 128'(bus.out_valid), 128'(0));
    check_eq("bp_release_count", 128'(bus.blk_count), 128'(2));

    // Key write during SETTLE is rejected
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = CT;
    step();
    bus.in_valid = 1'b0;
    bus.key_wr   = 1'b1;
    bus.key_in   = BAD;
    step();
    bus.key_wr = 1'b0;
    check_eq("kerr_pulse", 128'(bus.key_err), 128'(1));
    step();
    check_eq("kerr_clear", 128'(bus.key_err), 128'(0));
    wait_out("kerr", lat);
    check_eq("kerr_out_data", bus.out_data, PT);
    bus.out_ready = 1'b1;
    step();
    check_eq("kerr_blk_count", 128'(bus.blk_count), 128'(3));

    // Key write with in_valid in IDLE: no accept that cycle
    bus.key_wr   = 1'b1;
    bus.key_in   = KEY;
    bus.in_valid = 1'b1;
    bus.in_data  = CT;
    #1;
    check_eq("kwr_in_ready", 128'(bus.in_ready), 128'(0));
    step();
    bus.key_wr   = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("kwr_busy",    128'(bus.busy),    128'(0));
    check_eq("kwr_key_err", 128'(bus.key_err), 128'(0));

    // Counter wrap: preload near the top, then run back-to-back blocks
    force dut.r_blk_count = 16'hFFFE;
    #1;
    release dut.r_blk_count;
    step();
    check_eq("wrap_preload", 128'(bus.blk_count), 128'(16'hFFFE));
    bus.in_valid  = 1'b1;
    bus.in_data   = CT;
    bus.out_ready = 1'b1;
    wait_out("wrap0", lat);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        wait_out("wrapn", lat);
        check_eq("wrap_spacing", 128'(lat + 1), 128'(6));
      end
      check_eq("wrap_out_data", bus.out_data, PT);
      step();
      check_eq("wrap_count", 128'(bus.blk_count), 128'(16'(16'hFFFF + b)));
    end
    bus.in_valid = 1'b0;
    repeat (7) step();

    // Reset two edges after accept
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = CT;
    step();
    bus.in_valid = 1'b0;
    check_eq("mid_busy", 128'(bus.busy), 128'(1));
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("post_rst_in_ready",  128'(bus.in_ready),  128'(0));
    end
    bus.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
